// File: rtl/module_display_mux.sv
// Scanned 7-segment display multiplexer: shadows a packed hex word and drives one digit per tick.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module module_display_mux #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk_10Mhz_i,
  input  logic                  reset_i,
  input  logic                  tick_i,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic [2:0]            digit_o
);

  localparam logic [2:0] LAST_IDX = 3'(N_DIGITS - 1);
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  logic [4*N_DIGITS-1:0] shadow;
  logic [2:0]            next_idx;
  logic [3:0]            nibble;
  logic                  blank;
  logic [N_DIGITS-1:0]   an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // digit_o doubles as the scan index; the next digit is decoded ahead so outputs land one cycle after the tick.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    next_idx = (digit_o == LAST_IDX) ? 3'd0 : digit_o + 3'd1;
    nibble   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (next_idx == 3'(k)) nibble = shadow[4*k +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] zero_from;

  // zero_from[k] is set when nibble k and every higher nibble are zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    blank     = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run          = run & (shadow[4*k +: 4] == 4'h0);
      zero_from[k] = run;
    end
    for (int k = 1; k < N_DIGITS; k++) begin
      if (next_idx == 3'(k)) blank = zero_from[k];
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_next = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      an_next[k] = blank | (next_idx != 3'(k));
    end
  end

  always_ff @(posedge clk_10Mhz_i) begin
    if (reset_i) begin
      shadow  <= '0;
      digit_o <= '0;
      an_o    <= '1;
      seg_o   <= SEG_OFF;
    end else begin
      // NOTE: non-blocking updates mean a coincident tick decodes the shadow as it was before this edge's load.
      if (tick_i) begin
        digit_o <= next_idx;
        an_o    <= an_next;
        seg_o   <= blank ? SEG_OFF : seg_decode(nibble);
      end
      if (load_i) shadow <= data_i;
    end
  end

endmodule

// File: tb/tb_module_display_mux.sv
// Self-checking bench for module_display_mux: directed vector table, corner sequences,
// then random stimulus against a nibble-arithmetic reference model.
module tb_module_display_mux;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_i, tick_i, load_i;
  logic [4*N-1:0] data_i;
  logic [N-1:0] an_o;
  logic [6:0]   seg_o;
  logic [2:0]   digit_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  module_display_mux #(.N_DIGITS(N)) dut (
    .clk_10Mhz_i(clk),
    .reset_i    (reset_i),
    .tick_i     (tick_i),
    .load_i     (load_i),
    .data_i     (data_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .digit_o    (digit_o)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [4*N-1:0] m_shadow;
  int             m_idx;
  logic [N-1:0]   m_an;
  logic [6:0]     m_seg;
  int             m_dig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input int dig, input int an, input int seg);
    check({name, " digit"}, 32'(digit_o), dig);
    check({name, " an"},    32'(an_o),    an);
    check({name, " seg"},   32'(seg_o),   seg);
  endtask

  // Applies one cycle of inputs, advances the model at the edge, returns at the falling edge.
  task automatic step(input logic r, input logic t, input logic l, input logic [4*N-1:0] d);
    logic [4*N-1:0] upper;
    reset_i = r; tick_i = t; load_i = l; data_i = d;
    @(posedge clk);
    if (r) begin
      m_shadow = '0; m_idx = 0; m_dig = 0; m_an = '1; m_seg = 7'h7F;
    end else begin
      if (t) begin
        m_idx = (m_idx + 1) % N;
        upper = m_shadow >> (4 * m_idx);
        m_dig = m_idx;
        m_an  = ~(N'(1) << m_idx);
        m_seg = seg_tab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && upper == 0) begin
          m_an  = '1;
          m_seg = 7'h7F;
        end
`endif
      end
      if (l) m_shadow = d;
    end
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        rst, tick, load;
    logic [15:0] data;
    int          dig, an, seg;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset_i = 1'b1; tick_i = 1'b0; load_i = 1'b0; data_i = '0;
    @(negedge clk);

    // Digit k shows nibble k of the loaded word.
    vecs.push_back('{"reset",       1, 0, 0, 16'h0000, 0, 'hF, 'h7F});
    vecs.push_back('{"load1234",    0, 0, 1, 16'h1234, 0, 'hF, 'h7F});
    vecs.push_back('{"scan1",       0, 1, 0, 16'h0000, 1, 'hD, 'h30});
    vecs.push_back('{"scan2",       0, 1, 0, 16'h0000, 2, 'hB, 'h24});
    vecs.push_back('{"scan3",       0, 1, 0, 16'h0000, 3, 'h7, 'h79});
    vecs.push_back('{"scan0",       0, 1, 0, 16'h0000, 0, 'hE, 'h19});
    vecs.push_back('{"load00AF",    0, 0, 1, 16'h00AF, 0, 'hE, 'h19});
    vecs.push_back('{"load5555",    0, 0, 1, 16'h5555, 0, 'hE, 'h19});
    vecs.push_back('{"tick5555",    0, 1, 0, 16'h0000, 1, 'hD, 'h12});
    vecs.push_back('{"reset2",      1, 1, 1, 16'h1111, 0, 'hF, 'h7F});
    vecs.push_back('{"loadFFFF",    0, 0, 1, 16'hFFFF, 0, 'hF, 'h7F});
    vecs.push_back('{"hold1",       0, 1, 0, 16'h0000, 1, 'hD, 'h0E});
    vecs.push_back('{"hold2",       0, 1, 0, 16'h0000, 2, 'hB, 'h0E});
    vecs.push_back('{"hold3",       0, 1, 0, 16'h0000, 3, 'h7, 'h0E});
    vecs.push_back('{"hold4",       0, 1, 0, 16'h0000, 0, 'hE, 'h0E});
    vecs.push_back('{"hold5",       0, 1, 0, 16'h0000, 1, 'hD, 'h0E});
    vecs.push_back('{"hold6",       0, 1, 0, 16'h0000, 2, 'hB, 'h0E});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].load, vecs[i].data);
      expect_out(vecs[i].name, vecs[i].dig, vecs[i].an, vecs[i].seg);
    end

    // Coincident load and tick: the tick decodes the old all-zero shadow.
    step(1, 0, 0, 16'h0000);
    step(0, 1, 1, 16'h8888);
`ifdef LEADING_ZERO_BLANK_EN
    expect_out("coinc_old", 1, 'hF, 'h7F);
`else
    expect_out("coinc_old", 1, 'hD, 'h40);
`endif
    step(0, 1, 0, 16'h0000);
    expect_out("coinc_new", 2, 'hB, 'h00);

    // Full scan of 0007: leading digits blank only with the blanking feature.
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h0007);
    for (int k = 1; k <= N; k++) begin
      step(0, 1, 0, 16'h0000);
      if (k % N == 0) expect_out("lz_d0", 0, 'hE, 'h78);
      else begin
`ifdef LEADING_ZERO_BLANK_EN
        expect_out($sformatf("lz_d%0d", k), k, 'hF, 'h7F);
`else
        expect_out($sformatf("lz_d%0d", k), k, 4'hF & ~(4'h1 << k), 'h40);
`endif
      end
    end

    // Reset mid-scan with tick and load active, then confirm the shadow was cleared.
    step(1, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h1234);
    step(0, 1, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    expect_out("pre_rst", 2, 'hB, 'h24);
    step(1, 1, 1, 16'hFFFF);
    expect_out("mid_rst", 0, 'hF, 'h7F);
    step(0, 1, 0, 16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
    expect_out("post_rst", 1, 'hF, 'h7F);
`else
    expect_out("post_rst", 1, 'hD, 'h40);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0), 16'($urandom));
      check("rnd digit", 32'(digit_o), 32'(m_dig));
      check("rnd an",    32'(an_o),    32'(m_an));
      check("rnd seg",   32'(seg_o),   32'(m_seg));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
